// File: rtl/mem_stage_unit.sv
// Purpose : MEM pipeline stage; latches the EXE payload, aligns/extends SRAM load data, feeds WB and the ID forward bus.
// Latency : one cycle EXE->MEM register; load data and WB payload are combinational from the registered state.
// Backpressure: ms_allowin = !ms_valid | ws_allowin; SRAM read data is captured in a hold buffer while WB stalls.
//
// Ports:
//   clk, resetn        clock (rising edge) and asynchronous active-low reset
//   ws_allowin         WB can accept this cycle
//   ms_allowin         MEM can accept from EXE this cycle
//   es_to_ms_valid/bus EXE instruction {ld_op[4:0],res_from_mem,gr_we,dest[4:0],alu_res[31:0],pc[31:0]}
//   data_sram_rdata    synchronous SRAM read data, valid only in the cycle after the request
//   ms_to_ws_valid/bus instruction handed to WB {gr_we,dest[4:0],final_result[31:0],pc[31:0]}
//   ms_fwd_valid/dest/data  forwarding bus back to ID
//   out_ms_valid       MEM occupancy, for ID hazard logic

module mem_stage_unit #(
    parameter int ES_BUS_W = 76,
    parameter int WS_BUS_W = 70
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ws_allowin,
    output logic                ms_allowin,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    input  logic [31:0]         data_sram_rdata,
    output logic                ms_to_ws_valid,
    output logic [WS_BUS_W-1:0] ms_to_ws_bus,
    output logic                ms_fwd_valid,
    output logic [4:0]          ms_fwd_dest,
    output logic [31:0]         ms_fwd_data,
    output logic                out_ms_valid
);

    // ld_op = {ld_b, ld_bu, ld_h, ld_hu, ld_w}, one-hot or zero
    typedef struct packed {
        logic [4:0]  ld_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ws_bus_t;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b00010;
    localparam logic [4:0] LD_W  = 5'b00001;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic        ms_valid;
    logic        first_cyc;   // first occupancy cycle: live rdata belongs to this instruction
    logic        hold_vld;
    logic [31:0] hold_data;
    es_bus_t     bus_r;

    logic        ms_ready_go;
    logic        accept;
    logic        leave;

    assign ms_ready_go = 1'b1;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign accept      = es_to_ms_valid && ms_allowin;
    assign leave       = ms_valid && ms_ready_go && ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid  <= 1'b0;
            first_cyc <= 1'b0;
            hold_vld  <= 1'b0;
            hold_data <= 32'd0;
            bus_r     <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (accept) begin
                bus_r <= es_bus_t'(es_to_ms_bus);
            end
            first_cyc <= accept;

            // The SRAM only drives the load data for one cycle; if WB is not
            // taking the instruction in that cycle, keep a private copy so the
            // WB payload and forward data stay stable for the whole stall.
            // Leaving wins, so any instruction arriving next starts with an
            // empty hold buffer.
            if (leave) begin
                hold_vld <= 1'b0;
            end else if (first_cyc && ms_valid && bus_r.res_from_mem && !ws_allowin) begin
                hold_vld  <= 1'b1;
                hold_data <= data_sram_rdata;
            end
        end
    end

    // ---------------------------------------------------------------
    // Load data alignment and extension
    // ---------------------------------------------------------------
    logic [31:0] ld_raw;
    logic [1:0]  addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [31:0] final_result;

    assign ld_raw  = hold_vld ? hold_data : data_sram_rdata;
    assign addr_lo = bus_r.alu_res[1:0];

    always_comb begin
        ld_byte = ld_raw[7:0];
        case (addr_lo)
            2'd0: ld_byte = ld_raw[7:0];
            2'd1: ld_byte = ld_raw[15:8];
            2'd2: ld_byte = ld_raw[23:16];
            2'd3: ld_byte = ld_raw[31:24];
            default: ld_byte = ld_raw[7:0];
        endcase
    end

    // Halfword misalignment is rejected upstream, so only addr_lo[1] matters.
    assign ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];

    always_comb begin
        ld_result = ld_raw;
        case (bus_r.ld_op)
            LD_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_result = {24'd0, ld_byte};
            LD_H:    ld_result = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_result = {16'd0, ld_half};
            LD_W:    ld_result = ld_raw;
            default: ld_result = ld_raw;
        endcase
    end

    assign final_result = bus_r.res_from_mem ? ld_result : bus_r.alu_res;

    // ---------------------------------------------------------------
    // Outputs to WB and ID
    // ---------------------------------------------------------------
    ws_bus_t ws_bus;

    always_comb begin
        ws_bus              = '0;
        ws_bus.gr_we        = bus_r.gr_we;
        ws_bus.dest         = bus_r.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = bus_r.pc;
    end

    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_to_ws_bus   = ws_bus;

    assign ms_fwd_valid = ms_valid && bus_r.gr_we && (bus_r.dest != 5'd0);
    assign ms_fwd_dest  = bus_r.dest;
    assign ms_fwd_data  = final_result;
    assign out_ms_valid = ms_valid;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Purpose : randomized + directed bench for mem_stage_unit with a transaction-level scoreboard.
// Latency : expected WB payload is pushed when EXE hands over; monitor compares on every occupied cycle.
// Backpressure: ws_allowin is randomized; the bench plays the SRAM, driving junk rdata outside the first cycle.

module tb_mem_stage_unit;

    logic        clk;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;
    logic        out_ms_valid;

    mem_stage_unit #(.ES_BUS_W(76), .WS_BUS_W(70)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_fwd_valid    (ms_fwd_valid),
        .ms_fwd_dest     (ms_fwd_dest),
        .ms_fwd_data     (ms_fwd_data),
        .out_ms_valid    (out_ms_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ld_op;
        logic        rfm;
        logic        gwe;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
    } instr_t;

    typedef struct {
        logic        gwe;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          started = 0;
    bit          exp_occ = 0;   // model: MEM holds an instruction this cycle
    bit          nocc = 0;
    bit          nfirst = 0;
    bit          idle_fixed = 0;
    logic [31:0] idle_rd = 32'd0;
    logic [31:0] pend_rd = 32'd0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    // Reference: what WB must receive, from the architectural load rules.
    function automatic logic [31:0] expect_result(instr_t i, logic [31:0] raw);
        int unsigned a;
        logic [31:0] b;
        logic [31:0] h;
        a = i.alu % 4;
        b = (raw >> (8 * a)) & 32'hFF;
        h = (raw >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
        if (!i.rfm) return i.alu;
        case (i.ld_op)
            5'b10000: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            5'b01000: return b;
            5'b00100: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            5'b00010: return h;
            default:  return raw;
        endcase
    endfunction

    function automatic instr_t mk(logic [4:0] ld_op, logic rfm, logic gwe, logic [4:0] dest,
                                  logic [31:0] alu, logic [31:0] pc);
        instr_t i;
        i.ld_op = ld_op; i.rfm = rfm; i.gwe = gwe; i.dest = dest; i.alu = alu; i.pc = pc;
        return i;
    endfunction

    function automatic instr_t rand_instr(logic [31:0] pc);
        instr_t i;
        int k;
        k = $urandom_range(0, 7);
        i.ld_op = (k < 5) ? 5'(1 << k) : 5'd0;
        i.rfm   = (k <= 5);
        i.gwe   = ($urandom_range(0, 3) != 0);
        i.dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        i.alu   = $urandom;
        i.pc    = pc;
        return i;
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. rd_next is the SRAM data returned for this
    // instruction if EXE's handover is taken this cycle.
    task automatic step(input bit ev, input instr_t i, input bit ws, input logic [31:0] rd_next);
        bit   acc;
        bit   occ;
        bit   first;
        exp_t e;
        @(posedge clk);
        #1;
        occ     = nocc;
        first   = nfirst;
        exp_occ = occ;
        es_to_ms_valid  = ev;
        es_to_ms_bus    = {i.ld_op, i.rfm, i.gwe, i.dest, i.alu, i.pc};
        ws_allowin      = ws;
        data_sram_rdata = first ? pend_rd : (idle_fixed ? idle_rd : $urandom);
        acc = ev && (!occ || ws);
        if (acc) begin
            pend_rd = rd_next;
            e.gwe  = i.gwe;
            e.dest = i.dest;
            e.res  = expect_result(i, rd_next);
            e.pc   = i.pc;
            sb.push_back(e);
        end
        nocc   = acc || (occ && !ws);
        nfirst = acc;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn         = 1'b0;
        es_to_ms_valid = 1'b0;
        #1;
        check("rst_valid",     70'(ms_to_ws_valid), 70'(0));
        check("rst_allowin",   70'(ms_allowin),     70'(1));
        check("rst_fwd_valid", 70'(ms_fwd_valid),   70'(0));
        check("rst_out_valid", 70'(out_ms_valid),   70'(0));
        sb.delete();
        nocc    = 0;
        nfirst  = 0;
        exp_occ = 0;
        @(negedge clk);
        #1 resetn = 1'b1;
    endtask

    // Monitor: compares the DUT against the scoreboard head every cycle.
    always @(negedge clk) begin
        if (started && resetn) begin
            check("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(exp_occ));
            check("out_ms_valid",   70'(out_ms_valid),   70'(exp_occ));
            check("ms_allowin",     70'(ms_allowin),     70'(!exp_occ || ws_allowin));
            if (exp_occ) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 70'(sb.size()), 70'(1));
                end else begin
                    check("ws_bus", ms_to_ws_bus, {sb[0].gwe, sb[0].dest, sb[0].res, sb[0].pc});
                    check("fwd_valid", 70'(ms_fwd_valid), 70'(sb[0].gwe && (sb[0].dest != 5'd0)));
                    check("fwd_dest",  70'(ms_fwd_dest),  70'(sb[0].dest));
                    check("fwd_data",  70'(ms_fwd_data),  70'(sb[0].res));
                    if (ws_allowin) void'(sb.pop_front());
                end
            end else begin
                check("fwd_valid_idle", 70'(ms_fwd_valid), 70'(0));
            end
        end
    end

    initial begin
        instr_t g;
        resetn          = 1'b0;
        ws_allowin      = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = 32'd0;
        #2;
        check("init_valid",     70'(ms_to_ws_valid), 70'(0));
        check("init_allowin",   70'(ms_allowin),     70'(1));
        check("init_fwd_valid", 70'(ms_fwd_valid),   70'(0));
        check("init_out_valid", 70'(out_ms_valid),   70'(0));
        @(negedge clk);
        #1 resetn = 1'b1;
        started = 1;
        g = mk(5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

        // Word load with WB ready: one valid cycle carrying the live rdata.
        step(1, mk(5'b00001, 1, 1, 5'd3, 32'h0000_1000, 32'h100), 1, 32'hDEAD_BEEF);
        step(0, g, 1, 0);
        step(0, g, 1, 0);

        // Byte/halfword alignment and extension, back to back.
        step(1, mk(5'b10000, 1, 1, 5'd4, 32'h0000_2003, 32'h104), 1, 32'h8012_3456);
        step(1, mk(5'b01000, 1, 1, 5'd4, 32'h0000_2003, 32'h108), 1, 32'h8012_3456);
        step(1, mk(5'b00100, 1, 1, 5'd4, 32'h0000_2002, 32'h10C), 1, 32'h8012_3456);
        step(1, mk(5'b00010, 1, 1, 5'd4, 32'h0000_2000, 32'h110), 1, 32'h8012_3456);
        step(0, g, 1, 0);

        // Multi-cycle WB stall: SRAM output changes, result must not.
        step(1, mk(5'b00001, 1, 1, 5'd6, 32'h0000_3000, 32'h114), 1, 32'h1111_1111);
        idle_fixed = 1;
        idle_rd    = 32'h2222_2222;
        step(0, g, 0, 0);
        step(0, g, 0, 0);
        step(0, g, 0, 0);
        step(0, g, 1, 0);
        idle_fixed = 0;

        // ALU result forwarding, with and without a real destination.
        step(1, mk(5'd0, 0, 1, 5'd5, 32'h0000_0007, 32'h118), 1, 32'hFFFF_FFFF);
        step(1, mk(5'd0, 0, 1, 5'd0, 32'h0000_0007, 32'h11C), 1, 32'hFFFF_FFFF);
        step(0, g, 1, 0);

        // Reset while a load sits in the hold buffer, then a fresh load.
        step(1, mk(5'b00001, 1, 1, 5'd7, 32'h0000_4000, 32'h120), 1, 32'hAAAA_5555);
        step(0, g, 0, 0);
        step(0, g, 0, 0);
        do_reset();
        step(1, mk(5'b00001, 1, 1, 5'd8, 32'h0000_4004, 32'h124), 1, 32'h1234_5678);
        step(0, g, 1, 0);

        // Four-instruction stream, no bubbles.
        step(1, mk(5'b00001, 1, 1, 5'd9,  32'h0000_5000, 32'h200), 1, 32'h0A0A_0A0A);
        step(1, mk(5'd0,     0, 1, 5'd10, 32'h0000_0042, 32'h204), 1, 32'h0);
        step(1, mk(5'b10000, 1, 1, 5'd11, 32'h0000_5001, 32'h208), 1, 32'h0000_F300);
        step(1, mk(5'b00010, 1, 1, 5'd12, 32'h0000_5002, 32'h20C), 1, 32'hBEEF_0000);
        step(0, g, 1, 0);

        // Randomized traffic with random WB backpressure and occasional reset.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                g = rand_instr(pc_ctr);
                pc_ctr = pc_ctr + 32'd4;
                step($urandom_range(0, 9) < 7, g, $urandom_range(0, 9) < 6, $urandom);
            end
        end

        // Drain and confirm every issued instruction reached WB.
        for (int c = 0; c < 4; c++) step(0, g, 1, 0);
        @(negedge clk);
        #1;
        check("sb_drained", 70'(sb.size()), 70'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
